// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: FSM states and default source count.
package irq_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Request/consumer signal bundle for irq_controller; ovf exists only when IRQ_OVF_EN is defined.
interface irq_controller_if
  import irq_pkg::*;
#(
  parameter int N = DEFAULT_N
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   irq_in;
  logic [N-1:0]   mask;
  logic           irq_req;
  logic [IDW-1:0] irq_id;
  logic           irq_ack;
  logic [N-1:0]   pending;

`ifdef IRQ_OVF_EN
  logic [N-1:0]   ovf;

  modport master (
    input  irq_in, mask, irq_ack,
    output irq_req, irq_id, pending, ovf
  );

  modport slave (
    output irq_in, mask, irq_ack,
    input  irq_req, irq_id, pending, ovf
  );
`else
  modport master (
    input  irq_in, mask, irq_ack,
    output irq_req, irq_id, pending
  );

  modport slave (
    output irq_in, mask, irq_ack,
    input  irq_req, irq_id, pending
  );
`endif

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational highest-set-bit encoder; o_none flags an all-zero input vector.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter  int N   = DEFAULT_N,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_vec,
  output logic [IDW-1:0] o_idx,
  output logic           o_none
);

  // Ascending scan: the last set bit seen is the highest index, so it wins.
  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx  = IDW'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending latch, mask, fixed priority, REQ/ack handshake.
// Optional sticky lost-edge flags (ovf) are built when IRQ_OVF_EN is defined.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input logic              clk,
  input logic              rst,
  irq_controller_if.master bus
);

  localparam int IDW = $clog2(N);

  state_t         r_state;
  state_t         w_nextState;
  logic [N-1:0]   r_irqInD;
  logic [N-1:0]   r_pending;
  logic [IDW-1:0] r_irqId;
  logic [N-1:0]   w_edge;
  logic [N-1:0]   w_cand;
  logic [N-1:0]   w_clr;
  logic [IDW-1:0] w_candIdx;
  logic           w_none;
  logic           w_latch;
  logic           w_irqReq;

  assign w_edge = bus.irq_in & ~r_irqInD;
  assign w_cand = r_pending & ~bus.mask;

  irq_prio_enc #(.N(N)) u_prioEnc (
    .i_vec  (w_cand),
    .o_idx  (w_candIdx),
    .o_none (w_none)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The presented id is captured only on IDLE->REQ, so it holds for the whole request.
  always_comb begin
    w_nextState = r_state;
    w_latch     = 1'b0;
    w_clr       = '0;
    w_irqReq    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_none) begin
          w_latch     = 1'b1;
          w_nextState = REQ;
        end
      end
      REQ: begin
        w_irqReq = 1'b1;
        if (bus.irq_ack) begin
          w_clr       = N'(1) << r_irqId;
          w_nextState = GAP;
        end
      end
      GAP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // A new edge is OR-ed in after the ack clear, so set beats clear on the same source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irqInD  <= '0;
      r_pending <= '0;
      r_irqId   <= '0;
    end else begin
      r_irqInD  <= bus.irq_in;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (w_latch) begin
        r_irqId <= w_candIdx;
      end
    end
  end

  assign bus.irq_req = w_irqReq;
  assign bus.irq_id  = r_irqId;
  assign bus.pending = r_pending;

`ifdef IRQ_OVF_EN
  logic [N-1:0] r_ovf;

  // An edge landing on a still-pending source that is not being acked is a lost edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~w_clr) | (w_edge & r_pending & ~w_clr);
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (N=4); ovf checks are compiled in with IRQ_OVF_EN.
module tb_irq_controller;

  logic clk;
  logic rst;
  int   vecCount;
  int   missCount;

  irq_controller_if #(.N(4)) bus ();

  irq_controller #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic [3:0] irq, input logic [3:0] msk, input logic ack);
    bus.irq_in  = irq;
    bus.mask    = msk;
    bus.irq_ack = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecCount    = 0;
    missCount   = 0;
    rst         = 1'b1;
    bus.irq_in  = 4'b0000;
    bus.mask    = 4'b0000;
    bus.irq_ack = 1'b0;
    #12;
    checkOutput("rst_req", 32'(bus.irq_req), 32'd0);
    checkOutput("rst_pending", 32'(bus.pending), 32'd0);
    checkOutput("rst_id", 32'(bus.irq_id), 32'd0);
`ifdef IRQ_OVF_EN
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;

    // Single source: pending at +1, request at +2, ack clears.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("t1_pending", 32'(bus.pending), 32'h1);
    checkOutput("t1_req_early", 32'(bus.irq_req), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t1_req", 32'(bus.irq_req), 32'd1);
    checkOutput("t1_id", 32'(bus.irq_id), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t1_ack_pending", 32'(bus.pending), 32'h0);
    checkOutput("t1_ack_req", 32'(bus.irq_req), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Two simultaneous sources: highest first, then the other after the gap.
    applyStimulus(4'b1010, 4'b0000, 1'b0);
    checkOutput("t2_pending", 32'(bus.pending), 32'ha);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t2_req", 32'(bus.irq_req), 32'd1);
    checkOutput("t2_id3", 32'(bus.irq_id), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t2_gap_req", 32'(bus.irq_req), 32'd0);
    checkOutput("t2_gap_pending", 32'(bus.pending), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t2_idle_req", 32'(bus.irq_req), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t2_req1", 32'(bus.irq_req), 32'd1);
    checkOutput("t2_id1", 32'(bus.irq_id), 32'd1);

    // Presented id stays put despite a higher source and masking of itself.
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("t3_pending", 32'(bus.pending), 32'ha);
    checkOutput("t3_id_hold", 32'(bus.irq_id), 32'd1);
    applyStimulus(4'b0000, 4'b0010, 1'b0);
    checkOutput("t3_id_masked", 32'(bus.irq_id), 32'd1);
    checkOutput("t3_req_masked", 32'(bus.irq_req), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t3_ack_pending", 32'(bus.pending), 32'h8);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t3_req3", 32'(bus.irq_req), 32'd1);
    checkOutput("t3_id3", 32'(bus.irq_id), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Masked source stays pending, stray ack ignored, unmask presents it next cycle.
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    checkOutput("t4_pending", 32'(bus.pending), 32'h4);
    checkOutput("t4_req_masked", 32'(bus.irq_req), 32'd0);
    applyStimulus(4'b0000, 4'b0100, 1'b1);
    checkOutput("t4_stray_ack", 32'(bus.pending), 32'h4);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    checkOutput("t4_still_idle", 32'(bus.irq_req), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t4_unmask_req", 32'(bus.irq_req), 32'd1);
    checkOutput("t4_unmask_id", 32'(bus.irq_id), 32'd2);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Edge in the ack cycle wins over the clear; a later edge while pending is lost.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t5_id0", 32'(bus.irq_id), 32'd0);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("t5_set_wins", 32'(bus.pending), 32'h1);
    checkOutput("t5_gap_req", 32'(bus.irq_req), 32'd0);
`ifdef IRQ_OVF_EN
    checkOutput("t5_no_ovf", 32'(bus.ovf), 32'h0);
`endif
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("t5_represent_req", 32'(bus.irq_req), 32'd1);
    checkOutput("t5_represent_id", 32'(bus.irq_id), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("t5_repeat_pending", 32'(bus.pending), 32'h1);
`ifdef IRQ_OVF_EN
    checkOutput("t5_ovf_set", 32'(bus.ovf), 32'h1);
`endif
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("t5_ack_pending", 32'(bus.pending), 32'h0);
`ifdef IRQ_OVF_EN
    checkOutput("t5_ovf_clr", 32'(bus.ovf), 32'h0);
`endif

    // Asynchronous reset in the middle of a request.
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    checkOutput("t6_pending", 32'(bus.pending), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t6_req", 32'(bus.irq_req), 32'd1);
    checkOutput("t6_id2", 32'(bus.irq_id), 32'd2);
    applyStimulus(4'b1100, 4'b0000, 1'b0);
`ifdef IRQ_OVF_EN
    checkOutput("t6_ovf", 32'(bus.ovf), 32'h4);
`endif
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_req", 32'(bus.irq_req), 32'd0);
    checkOutput("t6_async_pending", 32'(bus.pending), 32'h0);
    checkOutput("t6_async_id", 32'(bus.irq_id), 32'd0);
`ifdef IRQ_OVF_EN
    checkOutput("t6_async_ovf", 32'(bus.ovf), 32'h0);
`endif

    // A line held high through reset counts as an edge on the first clock.
    bus.irq_in = 4'b1000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("t7_release_pending", 32'(bus.pending), 32'h8);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("t7_release_req", 32'(bus.irq_req), 32'd1);
    checkOutput("t7_release_id", 32'(bus.irq_id), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter N, default 4: number of request sources (power of two, 2..16).
REQ-002 The block SHALL have derived localparam IDW = $clog2(N): source-ID width.
REQ-003 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port irq_in, input, N: synchronous request lines, rising-edge sensitive.
REQ-006 The block SHALL have port mask, input, N: 1 = source masked (held pending, never presented).
REQ-007 The block SHALL have port irq_req, output, 1: interrupt request to consumer.
REQ-008 The block SHALL have port irq_id, output, IDW: index of presented source, valid while irq_req=1.
REQ-009 The block SHALL have port irq_ack, input, 1: consumer accepts the presented source.
REQ-010 The block SHALL have port pending, output, N: current pending register (unmasked view).
REQ-011 The block SHALL have port ovf, output, N, present only with IRQ_OVF_EN: sticky lost-edge flags.

Function
REQ-012 Edge detect SHALL be irq_in & ~irq_in_d, where irq_in_d is irq_in registered one cycle; an edge sets pending[i] on the next clock.
REQ-013 Candidate vector SHALL be pending & ~mask; highest index SHALL win (bit N-1 highest priority); a zero vector means no candidate.
REQ-014 FSM SHALL have states IDLE, REQ, GAP.
REQ-015 IDLE: if a candidate exists, latch its index into irq_id and go to REQ next cycle; otherwise stay.
REQ-016 REQ: irq_req=1; irq_id SHALL stay stable even if higher-priority sources become pending or the presented source is masked.
REQ-017 REQ with irq_ack=1: clear pending[irq_id], go to GAP; irq_req deasserts the following cycle.
REQ-018 GAP: irq_req=0 for exactly one cycle, then IDLE.
REQ-019 irq_ack outside REQ SHALL be ignored.
REQ-020 Edge on source i in the same cycle as its ack-clear: set SHALL win; pending[i] stays 1.
REQ-021 Edge on an already-pending source SHALL leave pending unchanged (edges are not counted).
REQ-022 Latency: edge on irq_in at cycle 0 -> pending at cycle 1 -> irq_req=1 at cycle 2 (when IDLE, unmasked, highest priority).
REQ-023 Unmasking a pending source SHALL make it a candidate in the same cycle the mask changes.

Reset
REQ-024 On rst: state=IDLE, pending=0, irq_in_d=0, irq_req=0, irq_id=0, ovf=0, asynchronously.
REQ-025 Reset asserted mid-REQ SHALL drop the request immediately; no ack is required afterwards.
REQ-026 irq_in_d reset value 0 SHALL cause lines high at reset release to register as edges on the first clock.

Configuration
REQ-027 With macro IRQ_OVF_EN defined: ovf port exists; ovf[i] SHALL set when an edge arrives on i while pending[i]=1 and not being cleared that cycle; it clears when source i is acked.
REQ-028 Without IRQ_OVF_EN: no ovf port, no ovf logic; all other behaviour identical.

Structure
REQ-029 A shared package irq_pkg SHALL hold the FSM state enum (IDLE, REQ, GAP) and the default N.
REQ-030 The highest-set-bit encode SHALL be a combinational sub-module irq_prio_enc (N in; IDW index out plus a none flag).

Verification
REQ-031 Reset then irq_in=0001 pulse -> pending=0001 at +1, irq_req=1 and irq_id=0 at +2; ack -> pending=0000, irq_req=0.
REQ-032 irq_in 0000->1010 in one cycle -> irq_id=3; ack -> GAP one cycle -> irq_id=1 presented.
REQ-033 While presenting id=1, raise irq_in[3] -> irq_id stays 1 until ack; then id=3 follows after GAP.
REQ-034 mask=0100, edge on bit 2 -> pending=0100, irq_req=0; clear mask -> irq_req=1 next cycle with irq_id=2.
REQ-035 Edge on bit 0 in the ack cycle of id=0 -> pending[0] remains 1, re-presented after GAP; with IRQ_OVF_EN, a second edge while pending -> ovf=0001.
REQ-036 Assert rst during REQ -> irq_req, pending, irq_id, ovf all 0 immediately, without a clock edge.
